// File: rtl/pipe_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rx_pkg
// Description : Shared defaults, pointer-width helper and state encoding for
//               the pipe_rx_buf receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_rx_pkg;

    localparam int unsigned c_DEF_WIDTH = 32;
    localparam int unsigned c_DEF_DEPTH = 32;
    localparam int unsigned c_DEF_PTR_W = $clog2(c_DEF_DEPTH);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_rx_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rx_buf_if
// Description : Producer/consumer bundle of the receive buffer. ovf_rx exists
//               only when PIPE_RX_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_rx_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
);
    logic [WIDTH-1:0]         i_rx;
    logic                     srdyi_rx;
    logic [WIDTH-1:0]         o_rx;
    logic                     srdyo_rx;
    logic                     drdyi_rx;
    logic [$clog2(DEPTH):0]   level_rx;
`ifdef PIPE_RX_OVF_EN
    logic                     ovf_rx;

    modport master (output i_rx, srdyi_rx, drdyi_rx,
                    input  o_rx, srdyo_rx, level_rx, ovf_rx);
    modport slave  (input  i_rx, srdyi_rx, drdyi_rx,
                    output o_rx, srdyo_rx, level_rx, ovf_rx);
`else
    modport master (output i_rx, srdyi_rx, drdyi_rx,
                    input  o_rx, srdyo_rx, level_rx);
    modport slave  (input  i_rx, srdyi_rx, drdyi_rx,
                    output o_rx, srdyo_rx, level_rx);
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_rx_ram.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rx_ram
// Description : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_rx_ram
    import pipe_rx_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned DEPTH = c_DEF_DEPTH,
    parameter int unsigned PTR_W = c_DEF_PTR_W
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are intentionally left unreset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pipe_rx_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rx_buf
// Description : First-word-fall-through buffer behind a non-stallable delay
//               pipe. Define PIPE_RX_OVF_EN for the sticky ovf_rx flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_rx_buf
    import pipe_rx_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned DEPTH = c_DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_rx_buf_if.slave rx
);

    localparam int unsigned c_PTR_W = ptr_width(DEPTH);
    localparam int unsigned c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_LVL_LAST = c_LVL_W'(DEPTH - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [WIDTH-1:0]     w_rdata;
    logic                 w_srdyo;
    logic                 w_pop;
    logic                 w_push;

    // A full buffer still accepts a word when the head leaves on the same edge.
    assign w_srdyo = (r_state != EMPTY);
    assign w_pop   = w_srdyo & rx.drdyi_rx;
    assign w_push  = rx.srdyi_rx & ((r_state != FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_push && !w_pop && (r_level == c_LVL_LAST)) begin
                    w_state_nxt = FULL;
                end else if (w_pop && !w_push && (r_level == c_LVL_ONE)) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop && !w_push) begin
                    w_state_nxt = ACTIVE;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_level <= r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
        end
    end

    pipe_rx_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (c_PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (rx.i_rx),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign rx.o_rx     = w_rdata;
    assign rx.srdyo_rx = w_srdyo;
    assign rx.level_rx = r_level;

`ifdef PIPE_RX_OVF_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop = rx.srdyi_rx & (r_state == FULL) & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign rx.ovf_rx = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_rx_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_rx_buf
// Description : Scoreboard bench for pipe_rx_buf (WIDTH=32, DEPTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_rx_buf;

    localparam int unsigned c_WIDTH = 32;
    localparam int unsigned c_DEPTH = 32;

    logic clk;
    logic rst_n;

    pipe_rx_buf_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) rx_if ();

    pipe_rx_buf #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    int          m_level  = 0;
    logic        m_ovf    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; the reference model decides acceptance and drops.
    task automatic step(input logic sv, input logic [31:0] d, input logic dr);
        logic pop;
        logic acc;
        rx_if.srdyi_rx = sv;
        rx_if.i_rx     = d;
        rx_if.drdyi_rx = dr;
        pop = (m_level != 0) && dr;
        acc = sv && ((m_level < int'(c_DEPTH)) || pop);
        if (acc) exp_q.push_back(d);
        if (sv && !acc) m_ovf = 1'b1;
        m_level = m_level + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
        chk("level", 32'(rx_if.level_rx), 32'(m_level));
        chk("srdyo", 32'(rx_if.srdyo_rx), 32'(m_level != 0));
`ifdef PIPE_RX_OVF_EN
        chk("ovf", 32'(rx_if.ovf_rx), 32'(m_ovf));
`endif
    endtask

    task automatic drain();
        for (int k = 0; k < int'(c_DEPTH) + 1; k++) begin
            if (m_level > 0) step(1'b0, 32'h0, 1'b1);
        end
    endtask

    // Monitor: every accepted output word must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_if.srdyo_rx && rx_if.drdyi_rx) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("data", rx_if.o_rx, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        rx_if.srdyi_rx = 1'b0;
        rx_if.i_rx     = '0;
        rx_if.drdyi_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(rx_if.level_rx), 32'd0);
        chk("rst_srdyo", 32'(rx_if.srdyo_rx), 32'd0);
`ifdef PIPE_RX_OVF_EN
        chk("rst_ovf", 32'(rx_if.ovf_rx), 32'd0);
`endif
        rst_n = 1'b1;

        // Single word into empty buffer with consumer ready: no same-cycle pop.
        step(1'b1, 32'h1, 1'b1);
        chk("first_head", rx_if.o_rx, 32'h1);
        chk("first_level", 32'(rx_if.level_rx), 32'd1);
        step(1'b0, 32'h0, 1'b1);
        chk("first_drained", 32'(rx_if.level_rx), 32'd0);

        // Fill to full, then a dropped push, then drain in order.
        for (int i = 0; i < 32; i++) step(1'b1, 32'(i), 1'b0);
        chk("full_level", 32'(rx_if.level_rx), 32'd32);
        step(1'b1, 32'hDEAD, 1'b0);
        chk("drop_level", 32'(rx_if.level_rx), 32'd32);
        chk("drop_head", rx_if.o_rx, 32'h0);
`ifdef PIPE_RX_OVF_EN
        chk("drop_ovf", 32'(rx_if.ovf_rx), 32'd1);
`endif
        drain();

        // Full buffer with simultaneous push and pop keeps both.
        for (int i = 0; i < 32; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
        step(1'b1, 32'h55, 1'b1);
        chk("fullpp_level", 32'(rx_if.level_rx), 32'd32);
        chk("fullpp_head", rx_if.o_rx, 32'h101);
        drain();

        // Streaming: 100 words, pointers wrap three times.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 32'h1000 + 32'(i), 1'b1);
            if (rx_if.level_rx > 1) chk("stream_level_max", 32'(rx_if.level_rx), 32'd1);
        end
        drain();

        // Reset overrides a simultaneous push and pop at level 10.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + 32'(i), 1'b0);
        chk("pre_rst_level", 32'(rx_if.level_rx), 32'd10);
        rst_n          = 1'b0;
        rx_if.srdyi_rx = 1'b1;
        rx_if.i_rx     = 32'h2FF;
        rx_if.drdyi_rx = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        chk("rst_pp_level", 32'(rx_if.level_rx), 32'd0);
        chk("rst_pp_srdyo", 32'(rx_if.srdyo_rx), 32'd0);
`ifdef PIPE_RX_OVF_EN
        chk("rst_pp_ovf", 32'(rx_if.ovf_rx), 32'd0);
`endif
        step(1'b0, 32'h0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if (rx_if.level_rx > 32) chk("rand_level_range", 32'(rx_if.level_rx), 32'd32);
        end
        drain();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_rx_buf.md
PIPE_RX_BUF -- requirements
Module: pipe_rx_buf

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter DEPTH, default 32: buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_rx  input  WIDTH  incoming data word from the fixed-latency delay pipe.
REQ-006 srdyi_rx  input  1  i_rx is valid this cycle; the source cannot stall and has no backpressure.
REQ-007 o_rx  output  WIDTH  head-of-buffer data word.
REQ-008 srdyo_rx  output  1  o_rx is valid.
REQ-009 drdyi_rx  input  1  consumer accepts o_rx this cycle.
REQ-010 level_rx  output  $clog2(DEPTH)+1  number of words currently stored.
REQ-011 ovf_rx  output  1  sticky overflow flag; present only under PIPE_RX_OVF_EN.

Function
REQ-012 Push: a word SHALL be written on each edge where srdyi_rx=1 and the buffer is not full, or is full with a pop on the same edge.
REQ-013 Pop: the head word SHALL be consumed on each edge where srdyo_rx=1 and drdyi_rx=1.
REQ-014 Order: words SHALL leave the buffer in arrival order, with no duplication or reordering.
REQ-015 Latency: a word pushed into an empty buffer at edge N SHALL appear on o_rx with srdyo_rx=1 after edge N; there is no same-cycle combinational bypass.
REQ-016 First-word-fall-through: o_rx SHALL always present the head word; o_rx is don't-care when srdyo_rx=0.
REQ-017 State machine has three states: EMPTY (level 0), ACTIVE (level 1..DEPTH-1) and FULL (level DEPTH); srdyo_rx=1 exactly in ACTIVE and FULL.
REQ-018 Transitions: EMPTY->ACTIVE on push; ACTIVE->FULL on push without pop at level DEPTH-1; ACTIVE->EMPTY on pop without push at level 1; FULL->ACTIVE on pop without push; otherwise the state holds.
REQ-019 Push with pop in ACTIVE or FULL SHALL leave level_rx unchanged and keep both operations.
REQ-020 Push in EMPTY with drdyi_rx=1 SHALL store the word; no pop occurs because srdyo_rx=0.
REQ-021 Push while FULL without pop SHALL drop the incoming word and leave the stored contents and level unchanged.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH with no dead cycle.
REQ-023 level_rx SHALL equal pushes minus pops since reset, saturating at DEPTH and 0 as defined above.

Reset
REQ-024 When rst_n=0 at an edge, the block SHALL enter EMPTY with pointers=0, level_rx=0, srdyo_rx=0 and ovf_rx=0; o_rx is don't-care.
REQ-025 Reset SHALL override a push or pop on the same edge; in-flight words are discarded.
REQ-026 Storage array contents SHALL NOT be reset.

Configuration
REQ-027 Macro PIPE_RX_OVF_EN defined: port ovf_rx SHALL exist and SHALL set on the edge following a dropped push (REQ-021), holding at 1 until reset.
REQ-028 PIPE_RX_OVF_EN undefined: port ovf_rx and its logic SHALL be absent; drop behaviour is unchanged.

Structure
REQ-029 Package pipe_rx_pkg SHALL hold the WIDTH and DEPTH defaults, the pointer-width constant and the state enum typedef (EMPTY, ACTIVE, FULL).
REQ-030 Storage SHALL be one sub-module pipe_rx_ram: DEPTH x WIDTH, one synchronous write port and one asynchronous read port; control stays in pipe_rx_buf.

Verification
REQ-031 Reset, then push 0x1 at edge 1 with drdyi_rx=1 -> after edge 1, srdyo_rx=1, o_rx=0x1 and level_rx=1; after edge 2, level_rx=0.
REQ-032 With drdyi_rx=0, push 0..31 -> FULL, level_rx=32; push 0xDEAD -> dropped, level_rx=32, ovf_rx=1 (macro on); drain -> 0..31 in order.
REQ-033 FULL with push 0x55 and pop on the same edge -> level_rx stays 32; 0x55 is read out last.
REQ-034 Continuous push and pop of 100 words with drdyi_rx=1 -> pointers wrap 3 times; output sequence matches input; level_rx is never above 1.
REQ-035 rst_n=0 at level 10 during a simultaneous push and pop -> after the edge, level_rx=0, srdyo_rx=0, ovf_rx=0.
REQ-036 Random srdyi_rx/drdyi_rx at 50% each for 10k cycles -> scoreboard matches; level_rx stays in 0..32.
